arrow_sequencer: RTL
====================

Name: arrow_sequencer

Overview:
Timing and command front end that drives the arrow board lamp decoder's phase, pattern, flashing and sequential inputs.
- Generates the phase[1:0] animation clock from the system clock using a prescaler.
- Accepts display commands over a valid/ready handshake.
- Applies each new command only at a frame boundary (phase wrapping 3->0), unless the command is marked immediate, so the lamps never show a half-changed animation.
- Sits between the host/input pins and the lamp decoder.

Parameters:
PHASE_DIV, 2500000, system clock cycles per phase step (one quarter frame); must be >= 2
DIV_WIDTH, 22, prescaler counter width; must satisfy 2**DIV_WIDTH >= PHASE_DIV

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  run enable; low freezes prescaler and phase
cmd_valid  input  1  command offered
cmd_ready  output  1  command can be accepted (= ~pending)
cmd_pattern  input  4  requested pattern code 0x0..0xF
cmd_flashing  input  1  requested flashing mode
cmd_sequential  input  1  requested sequential mode
cmd_immediate  input  1  apply now instead of at the frame boundary
phase  output  2  current animation phase to the decoder
pattern  output  4  active pattern to the decoder
flashing  output  1  active flashing flag
sequential  output  1  active sequential flag
frame_start  output  1  one-cycle pulse whenever phase becomes 0
pending  output  1  a shadow command is waiting for a boundary

Behaviour:
- Reset (async, rst_n low): prescaler=0, phase=0, pattern=0x0, flashing=0, sequential=0, shadow regs=0, pending=0, frame_start=0, so cmd_ready=1. Release is synchronous to the next clk edge.
- Prescaler:
  - With ena=1, counts 0..PHASE_DIV-1.
  - At PHASE_DIV-1 it wraps to 0 and asserts an internal tick for that cycle.
  - With ena=0, prescaler and phase hold.
- Phase: on tick, phase <= phase+1 mod 4. Outputs are registered; phase changes the cycle after tick.
- Boundary = tick while phase==3.
- Handshake:
  - Accept when cmd_valid & cmd_ready.
  - cmd_* are sampled only on accept.
  - cmd_ready is combinational from pending only, never from cmd_valid.
- State machine, two states:
  - RUN (pending=0):
    - Accept with cmd_immediate=1: pattern/flashing/sequential load next edge, phase<=0, prescaler<=0, frame_start=1 that cycle. Stay RUN. This works even when ena=0.
    - Accept with cmd_immediate=0: store in shadow, go PEND.
  - PEND (pending=1, cmd_ready=0):
    - On boundary: active regs <= shadow, phase<=0 (normal wrap), pending<=0, go RUN.
    - While ena=0, remain PEND indefinitely.
- frame_start: one cycle, coincident with phase register becoming 0, from either a boundary wrap or an immediate load. It does not fire on reset.
- Simultaneous events:
  - Boundary in RUN with a deferred accept in the same cycle: the command goes to shadow and is not applied this boundary. Applies at the next boundary, 4*PHASE_DIV cycles later.
  - Immediate accept coinciding with a tick: the immediate load wins; phase=0, prescaler=0.
- No arithmetic overflow beyond mod-4 phase; prescaler comparison is against PHASE_DIV-1 truncated to DIV_WIDTH.
- Reset mid-operation discards the shadow and pending command; the outstanding handshake is lost and the host must re-issue.

Decomposition:
- Shared package arrow_pkg:
  - Typedef pattern_t (4-bit).
  - Struct cmd_t {pattern, flashing, sequential}.
  - Constant PATTERN_RESET=4'h0.
  - Typedef seq_state_t {RUN, PEND}.
- One sub-module, arrow_prescaler: parameterised counter with ena, sync clear, tick output. It is reusable for other rate generators.
- Handshake/FSM and output registers stay in arrow_sequencer.

Test Plan:
All scenarios use PHASE_DIV=4.
1. Reset, ena=1, no commands -> phase sequence 0,0,0,0,1,1,1,1,2,... with one step every 4 cycles; frame_start pulses every 16 cycles starting at the first 3->0 wrap; pattern=0x0, cmd_ready=1.
2. Deferred command at phase=1: pattern=0x8, sequential=1, immediate=0 -> pending=1, cmd_ready=0, pattern stays 0x0 until the 3->0 wrap. Then pattern=0x8, sequential=1, pending=0, frame_start=1 the same cycle.
3. Immediate command at phase=2 mid-prescale: pattern=0xF, flashing=1 -> next cycle pattern=0xF, flashing=1, phase=0, frame_start=1; the next phase step occurs exactly 4 cycles later.
4. Deferred command accepted on the exact boundary cycle -> not applied at that wrap; applied 16 cycles later; pending stays high throughout.
5. ena=0 while pending -> phase frozen, pending stays 1, cmd_valid ignored (ready=0). Raise ena -> applies at the next boundary. Separately, immediate accept with ena=0 in RUN -> loads, phase=0.
6. Assert rst_n=0 asynchronously mid-PEND -> all outputs return to reset values without a clock edge; the shadow command is never applied after release.

Source files
------------

// File: rtl/arrow_pkg.sv
// Shared types and constants for the arrow board sequencer.
package arrow_pkg;

    typedef logic [3:0] pattern_t;

    typedef struct packed {
        pattern_t pattern;
        logic     flashing;
        logic     sequential;
    } cmd_t;

    localparam pattern_t PATTERN_RESET = 4'h0;

    localparam cmd_t CMD_RESET = '{pattern: PATTERN_RESET, flashing: 1'b0, sequential: 1'b0};

    typedef enum logic {RUN, PEND} seq_state_t;

endpackage

// File: rtl/arrow_prescaler.sv
// Free-running rate divider: counts 0..PHASE_DIV-1 while enabled and emits a one-cycle tick on wrap.
module arrow_prescaler #(
    parameter int unsigned PHASE_DIV = 2500000,
    parameter int unsigned DIV_WIDTH = 22
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_WIDTH-1:0] COUNT_TOP = DIV_WIDTH'(PHASE_DIV - 1);

    logic [DIV_WIDTH-1:0] count_q;
    logic [DIV_WIDTH-1:0] count_d;

    assign tick = ena && (count_q == COUNT_TOP);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else if (ena) begin
            count_d = count_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/arrow_sequencer.sv
// Phase generator and command front end for the arrow lamp decoder; deferred commands
// are held in a shadow register and applied only when the phase wraps 3->0.
module arrow_sequencer
    import arrow_pkg::*;
#(
    parameter int unsigned PHASE_DIV = 2500000,
    parameter int unsigned DIV_WIDTH = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_pattern,
    input  logic       cmd_flashing,
    input  logic       cmd_sequential,
    input  logic       cmd_immediate,
    output logic [1:0] phase,
    output logic [3:0] pattern,
    output logic       flashing,
    output logic       sequential,
    output logic       frame_start,
    output logic       pending
);

    seq_state_t state_q, state_d;
    logic [1:0] phase_q, phase_d;
    cmd_t       active_q, active_d;
    cmd_t       shadow_q, shadow_d;
    logic       frame_start_q, frame_start_d;

    logic tick;
    logic accept;
    logic imm_load;
    logic boundary;
    cmd_t cmd_in;

    assign cmd_in   = '{pattern: cmd_pattern, flashing: cmd_flashing, sequential: cmd_sequential};
    assign accept   = cmd_valid && cmd_ready;
    assign imm_load = accept && cmd_immediate;
    assign boundary = tick && (phase_q == 2'd3);

    arrow_prescaler #(
        .PHASE_DIV (PHASE_DIV),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (imm_load),
        .tick  (tick)
    );

    // Immediate loads override the normal phase step, so they are resolved last.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        frame_start_d = 1'b0;

        if (tick) begin
            phase_d = phase_q + 2'd1;
        end
        if (boundary) begin
            frame_start_d = 1'b1;
        end

        unique case (state_q)
            RUN: begin
                if (accept) begin
                    if (cmd_immediate) begin
                        active_d      = cmd_in;
                        phase_d       = 2'd0;
                        frame_start_d = 1'b1;
                    end else begin
                        shadow_d = cmd_in;
                        state_d  = PEND;
                    end
                end
            end
            PEND: begin
                if (boundary) begin
                    active_d = shadow_q;
                    state_d  = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            phase_q       <= 2'd0;
            active_q      <= CMD_RESET;
            shadow_q      <= CMD_RESET;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pending     = (state_q == PEND);
    assign cmd_ready   = ~pending;
    assign phase       = phase_q;
    assign pattern     = active_q.pattern;
    assign flashing    = active_q.flashing;
    assign sequential  = active_q.sequential;
    assign frame_start = frame_start_q;

endmodule
